// File: rtl/gold_code_correlator_pkg.sv
// rtl/gold_code_correlator_pkg.sv - shared types, sizing constants and chip helper for the gold-code correlator
package gold_corr_pkg;

    localparam int CODE_LEN_DEF = 1023;
    localparam int CNT_W_DEF    = $clog2(CODE_LEN_DEF);
    // One extra bit over the magnitude so that both +CODE_LEN and -CODE_LEN fit.
    localparam int ACC_W_DEF    = $clog2(CODE_LEN_DEF + 1) + 1;
    localparam int THRESH_DEF   = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Maps a chip bit onto its antipodal value: 1 -> +1, 0 -> -1.
    function automatic logic signed [1:0] chip_to_sign(input logic chip);
        return chip ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/gold_code_correlator_if.sv
// rtl/gold_code_correlator_if.sv - chip-stream and correlation-result bundle between generator, correlator and pin mux
interface gold_code_correlator_if
    import gold_corr_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);

    logic                    start;
    logic                    chip_valid;
    logic                    chip_in;
    logic                    ref_chip;
    logic signed [ACC_W-1:0] corr_out;
    logic                    corr_valid;
    logic                    lock;
    logic                    busy;
    logic        [ACC_W-1:0] peak_out;
    logic        [7:0]       peak_epoch;

    modport master (
        output start, chip_valid, chip_in, ref_chip,
        input  corr_out, corr_valid, lock, busy, peak_out, peak_epoch
    );

    modport slave (
        input  start, chip_valid, chip_in, ref_chip,
        output corr_out, corr_valid, lock, busy, peak_out, peak_epoch
    );

endinterface

// File: rtl/gold_code_correlator_accum.sv
// rtl/gold_code_correlator_accum.sv - signed +/-1 accumulator, chip counter and epoch-end detect
module corr_accum
    import gold_corr_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    active,
    input  logic                    chip_valid,
    input  logic                    chip_in,
    input  logic                    ref_chip,
    output logic                    epoch_end,
    output logic signed [ACC_W-1:0] final_sum
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_LEN - 1);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] contrib;
    logic        [CNT_W-1:0] cnt_q;

    assign contrib   = ACC_W'(chip_to_sign(chip_in ~^ ref_chip));
    assign final_sum = acc_q + contrib;
    // A start in the same cycle as the last chip realigns instead of dumping.
    assign epoch_end = active && chip_valid && !start && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            acc_q <= chip_valid ? contrib : '0;
            cnt_q <= chip_valid ? CNT_W'(1) : '0;
        end else if (active && chip_valid) begin
            if (cnt_q == LAST_CNT) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= final_sum;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gold_code_correlator.sv
// rtl/gold_code_correlator.sv - epoch correlator with lock detect; peak hold enabled by GOLD_CORR_PEAK_HOLD_EN
module gold_code_correlator
    import gold_corr_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int THRESH   = THRESH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    gold_code_correlator_if.slave  bus
);

    localparam logic [ACC_W-1:0] THRESH_W = ACC_W'(THRESH);

    state_t                  state_q;
    state_t                  state_d;
    logic                    dump;
    logic signed [ACC_W-1:0] final_sum;
    logic        [ACC_W-1:0] abs_sum;
    logic signed [ACC_W-1:0] corr_q;
    logic                    corr_valid_q;
    logic                    lock_q;
    logic        [7:0]       epoch_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once started the correlator free-runs epoch after epoch; only reset returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ACCUM;
        end
    end

    corr_accum #(
        .CODE_LEN (CODE_LEN),
        .CNT_W    (CNT_W),
        .ACC_W    (ACC_W)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .active     (state_q == ACCUM),
        .chip_valid (bus.chip_valid),
        .chip_in    (bus.chip_in),
        .ref_chip   (bus.ref_chip),
        .epoch_end  (dump),
        .final_sum  (final_sum)
    );

    // -CODE_LEN negates cleanly in ACC_W bits, so the magnitude never wraps.
    assign abs_sum = final_sum[ACC_W-1] ? ACC_W'(-final_sum) : ACC_W'(final_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q       <= '0;
            corr_valid_q <= 1'b0;
            lock_q       <= 1'b0;
            epoch_idx_q  <= '0;
        end else begin
            corr_valid_q <= dump;
            if (dump) begin
                corr_q      <= final_sum;
                lock_q      <= (abs_sum >= THRESH_W);
                epoch_idx_q <= epoch_idx_q + 8'd1;
            end
        end
    end

    assign bus.corr_out   = corr_q;
    assign bus.corr_valid = corr_valid_q;
    assign bus.lock       = lock_q;
    assign bus.busy       = (state_q == ACCUM);

`ifdef GOLD_CORR_PEAK_HOLD_EN
    logic [ACC_W-1:0] peak_q;
    logic [7:0]       peak_epoch_q;

    // Strict compare keeps the earliest epoch on a tie; start leaves the peak alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q       <= '0;
            peak_epoch_q <= '0;
        end else if (dump && (abs_sum > peak_q)) begin
            peak_q       <= abs_sum;
            peak_epoch_q <= epoch_idx_q;
        end
    end

    assign bus.peak_out   = peak_q;
    assign bus.peak_epoch = peak_epoch_q;
`else
    assign bus.peak_out   = '0;
    assign bus.peak_epoch = '0;
`endif

endmodule

// File: tb/tb_gold_code_correlator.sv
// tb/tb_gold_code_correlator.sv - directed table-driven bench for gold_code_correlator
module tb_gold_code_correlator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gold_code_correlator_if #(.ACC_W(11)) bus ();

    gold_code_correlator #(
        .CODE_LEN (1023),
        .CNT_W    (10),
        .ACC_W    (11),
        .THRESH   (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int dump_cnt = 0;

    always @(posedge clk) begin
        #2;
        if (bus.corr_valid === 1'b1) dump_cnt++;
    end

    typedef struct {
        int                 n_match;
        int                 n_mism;
        int                 gap;
        logic signed [31:0] exp_sum;
        logic               exp_lock;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic c, input logic r);
        @(negedge clk);
        bus.start      = st;
        bus.chip_valid = v;
        bus.chip_in    = c;
        bus.ref_chip   = r;
    endtask

    task automatic matched_chips(input int n);
        logic r;
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom_range(0, 1));
            drive(1'b0, 1'b1, r, r);
        end
    endtask

    task automatic run_epoch(input int nm, input int nx, input int gap,
                             input logic signed [31:0] exp_sum, input logic exp_lock,
                             input string tag);
        int   d0;
        int   n;
        logic r;
        d0 = dump_cnt;
        n  = nm + nx;
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom_range(0, 1));
            drive(1'b0, 1'b1, (i < nm) ? r : ~r, r);
            if (i < n - 1) repeat (gap) drive(1'b0, 1'b0, ~r, r);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, " corr_valid latency"}, 32'(bus.corr_valid), 1);
        check({tag, " corr_out"}, 32'(bus.corr_out), exp_sum);
        check({tag, " lock"}, 32'(bus.lock), 32'(exp_lock));
        check({tag, " dump count"}, dump_cnt, d0 + 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, " corr_valid width"}, 32'(bus.corr_valid), 0);
    endtask

    int d_save;

    initial begin
        vecs[0] = '{1023,    0, 0,  1023, 1'b1};
        vecs[1] = '{   0, 1023, 0, -1023, 1'b1};
        vecs[2] = '{ 511,  512, 0,    -1, 1'b0};
        vecs[3] = '{ 640,  383, 0,   257, 1'b1};
        vecs[4] = '{ 639,  384, 0,   255, 1'b0};
        vecs[5] = '{ 384,  639, 0,  -255, 1'b0};
        vecs[6] = '{ 383,  640, 0,  -257, 1'b1};
        vecs[7] = '{1023,    0, 1,  1023, 1'b1};
        vecs[8] = '{ 768,  255, 2,   513, 1'b1};

        bus.start = 1'b0; bus.chip_valid = 1'b0; bus.chip_in = 1'b0; bus.ref_chip = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset corr_out", 32'(bus.corr_out), 0);
        check("reset corr_valid", 32'(bus.corr_valid), 0);
        check("reset lock", 32'(bus.lock), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset peak_out", 32'(bus.peak_out), 0);
        check("reset peak_epoch", 32'(bus.peak_epoch), 0);

        d_save = dump_cnt;
        matched_chips(1030);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle ignores chips", dump_cnt, d_save);
        check("idle busy", 32'(bus.busy), 0);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("busy after start", 32'(bus.busy), 1);

        for (int v = 0; v < 9; v++) begin
            run_epoch(vecs[v].n_match, vecs[v].n_mism, vecs[v].gap,
                      vecs[v].exp_sum, vecs[v].exp_lock, $sformatf("vec%0d", v));
        end

`ifndef GOLD_CORR_PEAK_HOLD_EN
        check("peak_out tied", 32'(bus.peak_out), 0);
        check("peak_epoch tied", 32'(bus.peak_epoch), 0);
`endif

        // Realign after 500 chips; the realigning start carries chip 0.
        d_save = dump_cnt;
        matched_chips(500);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        matched_chips(1021);
        check("realign no early dump", dump_cnt, d_save);
        run_epoch(1, 0, 0, 1023, 1'b1, "realign");

        // Start on what would be the last chip wins: no dump, that chip opens the new epoch.
        d_save = dump_cnt;
        matched_chips(1022);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("start beats epoch end", dump_cnt, d_save);
        check("start beats epoch end valid", 32'(bus.corr_valid), 0);
        matched_chips(1021);
        run_epoch(1, 0, 0, 1021, 1'b1, "after collision");

        // Reset mid-epoch discards the partial sum.
        d_save = dump_cnt;
        matched_chips(300);
        @(negedge clk);
        rst = 1'b1;
        bus.chip_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst corr_out", 32'(bus.corr_out), 0);
        check("midrst lock", 32'(bus.lock), 0);
        check("midrst busy", 32'(bus.busy), 0);
        check("midrst corr_valid", 32'(bus.corr_valid), 0);
        check("midrst peak_out", 32'(bus.peak_out), 0);
        check("midrst no dump", dump_cnt, d_save);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run_epoch(0, 1023, 0, -1023, 1'b1, "post reset");

`ifdef GOLD_CORR_PEAK_HOLD_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run_epoch(562, 461, 0,  101, 1'b0, "peak e0");
        run_epoch( 61, 962, 0, -901, 1'b1, "peak e1");
        run_epoch(962,  61, 0,  901, 1'b1, "peak e2");
        check("peak_out", 32'(bus.peak_out), 901);
        check("peak_epoch", 32'(bus.peak_epoch), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
